// File: rtl/score_display_pkg.sv
// rtl/score_display_pkg.sv - segment codes, FSM state type and decimal range helper for score_display.
package score_display_pkg;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      LATCH = 2'd2
   } state_t;

   // Largest value representable on the given number of decimal digits.
   function automatic int max_dec(input int digits);
      int r;
      r = 1;
      for (int i = 0; i < digits; i++) r = r * 10;
      return r - 1;
   endfunction

   function automatic logic [6:0] seg_code(input logic [3:0] nibble);
      case (nibble)
         4'd0:    return SEG_0;
         4'd1:    return SEG_1;
         4'd2:    return SEG_2;
         4'd3:    return SEG_3;
         4'd4:    return SEG_4;
         4'd5:    return SEG_5;
         4'd6:    return SEG_6;
         4'd7:    return SEG_7;
         4'd8:    return SEG_8;
         4'd9:    return SEG_9;
         default: return SEG_BLANK;
      endcase
   endfunction

endpackage

// File: rtl/score_display_if.sv
// rtl/score_display_if.sv - load/ready request and display result bundle for score_display.
interface score_display_if #(
   parameter int WIDTH  = 10,
   parameter int DIGITS = 3
);
   logic [WIDTH-1:0]       value;
   logic                   load;
   logic                   ready;
   logic                   overflow;
   logic [DIGITS-1:0][6:0] leds;

   modport master (output value, load, input ready, overflow, leds);
   modport slave  (input value, load, output ready, overflow, leds);
endinterface

// File: rtl/score_display_seg_digit_enc.sv
// rtl/score_display_seg_digit_enc.sv - one BCD nibble to active-low gfedcba segments, with forced blank.
module seg_digit_enc
   import score_display_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       blank,
   output logic [6:0] seg
);
   assign seg = blank ? SEG_BLANK : seg_code(nibble);
endmodule

// File: rtl/score_display.sv
// rtl/score_display.sv - sequential double-dabble score to seven-segment driver.
// Optional leading-zero blanking when SCORE_DISPLAY_LZB_EN is defined.
module score_display
   import score_display_pkg::*;
#(
   parameter int WIDTH  = 10,
   parameter int DIGITS = 3
) (
   input  logic            clk,
   input  logic            reset_n,
   score_display_if.slave  bus
);
   localparam int          BCDW = DIGITS * 4;
   localparam int          CW   = $clog2(WIDTH + 1);
   localparam logic [31:0] MAXV = 32'(max_dec(DIGITS));
`ifdef SCORE_DISPLAY_LZB_EN
   localparam logic [6:0]  RST_UPPER = SEG_BLANK;
`else
   localparam logic [6:0]  RST_UPPER = SEG_0;
`endif

   state_t                 state;
   logic [BCDW-1:0]        bcd;
   logic [BCDW-1:0]        bcd_adj;
   logic [WIDTH-1:0]       bin;
   logic [CW-1:0]          cnt;
   logic                   ovf_cap;
   logic                   ovf_q;
   logic [DIGITS-1:0][6:0] leds_q;
   logic [DIGITS-1:0][6:0] seg_out;
   logic [DIGITS-1:0]      blank;
   logic                   accept;

   // LATCH counts as ready so a held load is taken on the latching edge.
   assign bus.ready    = (state != SHIFT);
   assign bus.leds     = leds_q;
   assign bus.overflow = ovf_q;
   assign accept       = bus.load && bus.ready;

   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
      end
   end

`ifdef SCORE_DISPLAY_LZB_EN
   always_comb begin
      logic nz;
      nz    = 1'b0;
      blank = '0;
      for (int i = DIGITS - 1; i > 0; i--) begin
         nz       = nz | (bcd[i*4 +: 4] != 4'd0);
         blank[i] = !nz;
      end
   end
`else
   assign blank = '0;
`endif

   for (genvar g = 0; g < DIGITS; g++) begin : g_dig
      seg_digit_enc u_enc (
         .nibble (bcd[g*4 +: 4]),
         .blank  (blank[g]),
         .seg    (seg_out[g])
      );
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         bcd     <= '0;
         bin     <= '0;
         cnt     <= '0;
         ovf_cap <= 1'b0;
         ovf_q   <= 1'b0;
         for (int i = 0; i < DIGITS; i++) leds_q[i] <= (i == 0) ? SEG_0 : RST_UPPER;
      end else begin
         case (state)
            IDLE: ;
            SHIFT: begin
               {bcd, bin} <= {bcd_adj, bin} << 1;
               cnt        <= cnt - 1'b1;
               if (cnt == CW'(1)) state <= LATCH;
            end
            LATCH: begin
               leds_q <= ovf_cap ? {DIGITS{SEG_DASH}} : seg_out;
               ovf_q  <= ovf_cap;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
         if (accept) begin
            bin     <= bus.value;
            bcd     <= '0;
            cnt     <= CW'(WIDTH);
            ovf_cap <= ({{(32-WIDTH){1'b0}}, bus.value} > MAXV);
            state   <= SHIFT;
         end
      end
   end
endmodule
